// File: rtl/lb_pkg.sv
// Shared types, defaults and helpers for the load-buffer table controller.
package lb_pkg;

    localparam int LB_ENTRIES = 4;
    localparam int LB_ADDR_W  = 32;
    localparam int LB_DATA_W  = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_MISS_REQ,
        ST_MISS_WAIT,
        ST_RESP
    } lb_state_e;

    // One table entry at the default widths.
    typedef struct packed {
        logic                 valid;
        logic [LB_ADDR_W-1:0] addr;
        logic [LB_DATA_W-1:0] data;
    } lb_entry_t;

    // Index width for a table of n entries; never narrower than one bit.
    function automatic int lb_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lb_match.sv
// Parallel address compare over the table: lookup hit with encoded index,
// per-entry store-snoop match, and lowest-index free-entry encoder.
module lb_match #(
    parameter int ENTRIES = 4,
    parameter int ADDR_W  = 32,
    parameter int IDX_W   = 2
) (
    input  logic [ENTRIES-1:0]             valid,
    input  logic [ENTRIES-1:0][ADDR_W-1:0] addr,
    input  logic [ADDR_W-1:0]              lk_addr,
    input  logic [ADDR_W-1:0]              st_addr,
    output logic                           lk_hit,
    output logic [IDX_W-1:0]               lk_idx,
    output logic [ENTRIES-1:0]             st_hit_oh,
    output logic                           free_any,
    output logic [IDX_W-1:0]               free_idx
);

    logic [ENTRIES-1:0] lk_hit_oh;

    // Compare every entry; scanning downwards leaves the lowest index as winner.
    // NOTE: every combinational output gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        lk_hit_oh = '0;
        st_hit_oh = '0;
        lk_idx    = '0;
        free_any  = 1'b0;
        free_idx  = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            lk_hit_oh[i] = valid[i] && (addr[i] == lk_addr);
            st_hit_oh[i] = valid[i] && (addr[i] == st_addr);
            if (lk_hit_oh[i]) begin
                lk_idx = IDX_W'(i);
            end
            if (!valid[i]) begin
                free_any = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    assign lk_hit = |lk_hit_oh;

endmodule

// File: rtl/lb_table_ctrl.sv
// Load-buffer controller: answers loads from a small fully-associative table,
// sequences a memory read on a miss, and keeps entries coherent with stores/flush.
module lb_table_ctrl
    import lb_pkg::*;
#(
    parameter int ENTRIES = LB_ENTRIES,
    parameter int ADDR_W  = LB_ADDR_W,
    parameter int DATA_W  = LB_DATA_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              ld_req_valid,
    input  logic [ADDR_W-1:0] ld_req_addr,
    output logic              ld_req_ready,
    output logic              ld_resp_valid,
    output logic [DATA_W-1:0] ld_resp_data,
    output logic              ld_resp_hit,
    input  logic              st_valid,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic              flush,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic [ADDR_W-1:0] dmem_req_addr,
    input  logic              dmem_resp_valid,
    input  logic [DATA_W-1:0] dmem_resp_data,
    output logic              port_lb_table_valid,
    output logic [ADDR_W-1:0] port_lb_table_addr,
    output logic [DATA_W-1:0] port_lb_table_data
);

    localparam int IDX_W = lb_idx_w(ENTRIES);

    lb_state_e                      state_q, state_d;
    logic [ADDR_W-1:0]              addr_q, addr_d;
    logic [DATA_W-1:0]              data_q, data_d;
    logic                           poison_q, poison_d;
    logic [ENTRIES-1:0]             valid_q, valid_d;
    logic [IDX_W-1:0]               rr_q, rr_d;
    logic                           obs_valid_q, obs_valid_d;
    logic [ADDR_W-1:0]              obs_addr_q, obs_addr_d;
    logic [DATA_W-1:0]              obs_data_q, obs_data_d;
    logic [IDX_W-1:0]               obs_idx_q, obs_idx_d;
    logic [ENTRIES-1:0][ADDR_W-1:0] tbl_addr_q;
    logic [DATA_W-1:0]              tbl_data_q [ENTRIES];

    logic                           lk_hit, free_any, fill_en, st_kill, miss_pending;
    logic [IDX_W-1:0]               lk_idx, free_idx, victim_idx;
    logic [ENTRIES-1:0]             st_hit_oh;

    lb_match #(
        .ENTRIES (ENTRIES),
        .ADDR_W  (ADDR_W),
        .IDX_W   (IDX_W)
    ) u_match (
        .valid     (valid_q),
        .addr      (tbl_addr_q),
        .lk_addr   (addr_q),
        .st_addr   (st_addr),
        .lk_hit    (lk_hit),
        .lk_idx    (lk_idx),
        .st_hit_oh (st_hit_oh),
        .free_any  (free_any),
        .free_idx  (free_idx)
    );

    assign ld_req_ready        = (state_q == ST_IDLE) && reset_n;
    assign dmem_req_addr       = addr_q;
    assign port_lb_table_valid = obs_valid_q;
    assign port_lb_table_addr  = obs_addr_q;
    assign port_lb_table_data  = obs_data_q;

    // Next-state, outputs, snoop/flush invalidation, fill and observation update.
    // NOTE: combinational logic uses blocking '=' so later statements see earlier updates; flops use '<=' only.
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        data_d         = data_q;
        poison_d       = poison_q;
        valid_d        = valid_q;
        rr_d           = rr_q;
        obs_valid_d    = obs_valid_q;
        obs_addr_d     = obs_addr_q;
        obs_data_d     = obs_data_q;
        obs_idx_d      = obs_idx_q;
        fill_en        = 1'b0;
        ld_resp_valid  = 1'b0;
        ld_resp_hit    = 1'b0;
        ld_resp_data   = '0;
        dmem_req_valid = 1'b0;
        victim_idx     = free_any ? free_idx : rr_q;
        st_kill        = st_valid && (st_addr == addr_q);
        miss_pending   = (state_q == ST_MISS_REQ) || (state_q == ST_MISS_WAIT);

        case (state_q)
            ST_IDLE: begin
                if (ld_req_valid) begin
                    addr_d  = ld_req_addr;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                // A same-cycle store (or flush) to the address beats the hit.
                if (lk_hit && !st_kill && !flush) begin
                    ld_resp_valid = 1'b1;
                    ld_resp_hit   = 1'b1;
                    ld_resp_data  = tbl_data_q[lk_idx];
                    state_d       = ST_IDLE;
                end else begin
                    state_d = ST_MISS_REQ;
                end
            end
            ST_MISS_REQ: begin
                dmem_req_valid = 1'b1;
                if (dmem_req_ready) begin
                    state_d = ST_MISS_WAIT;
                end
            end
            ST_MISS_WAIT: begin
                if (dmem_resp_valid) begin
                    data_d  = dmem_resp_data;
                    fill_en = !poison_q && !st_kill && !flush;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                ld_resp_valid = 1'b1;
                ld_resp_data  = data_q;
                poison_d      = 1'b0;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Data read for the outstanding miss may be stale: return it but never fill it.
        if (miss_pending && (st_kill || flush)) begin
            poison_d = 1'b1;
        end

        if (st_valid) begin
            valid_d = valid_d & ~st_hit_oh;
        end

        if (fill_en) begin
            valid_d[victim_idx] = 1'b1;
            if (!free_any) begin
                rr_d = rr_q + IDX_W'(1);
            end
        end

        if (flush) begin
            valid_d = '0;
            rr_d    = '0;
        end

        // Observation tracks the last-filled entry until that entry is invalidated.
        if (fill_en) begin
            obs_valid_d = 1'b1;
            obs_addr_d  = addr_q;
            obs_data_d  = dmem_resp_data;
            obs_idx_d   = victim_idx;
        end else begin
            obs_valid_d = obs_valid_q && valid_d[obs_idx_q];
        end
    end

    // Control state and observation registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            poison_q    <= 1'b0;
            valid_q     <= '0;
            rr_q        <= '0;
            obs_valid_q <= 1'b0;
            obs_addr_q  <= '0;
            obs_data_q  <= '0;
            obs_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            poison_q    <= poison_d;
            valid_q     <= valid_d;
            rr_q        <= rr_d;
            obs_valid_q <= obs_valid_d;
            obs_addr_q  <= obs_addr_d;
            obs_data_q  <= obs_data_d;
            obs_idx_q   <= obs_idx_d;
        end
    end

    // Table payload storage, written only on a fill.
    // NOTE: the payload arrays are deliberately not reset; the reset valid bits make their contents irrelevant.
    always_ff @(posedge clock) begin
        if (fill_en) begin
            tbl_addr_q[victim_idx] <= addr_q;
            tbl_data_q[victim_idx] <= dmem_resp_data;
        end
    end

endmodule

// File: doc/lb_table_ctrl.md
Name: lb_table_ctrl

Overview:
- Controller for the load-buffer (lb_table) resource in the 5-stage Sodor core.
- Accepts load lookups from the memory stage and answers hits from a small fully-associative table.
- On a miss, sequences a data-memory read, fills the table and returns the data.
- Snoops stores and flushes to keep entries coherent; exposes the last-written entry on observation ports for the two-copy divergence harness.

Parameters:
- ENTRIES, 4, number of table entries; power of two, 2..16.
- ADDR_W, 32, load/store address width.
- DATA_W, 32, load data width.

Ports:
- clock  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- ld_req_valid  in  1  load lookup request.
- ld_req_addr  in  ADDR_W  load byte address.
- ld_req_ready  out  1  high only in IDLE.
- ld_resp_valid  out  1  one-cycle pulse with result.
- ld_resp_data  out  DATA_W  load result.
- ld_resp_hit  out  1  result came from table.
- st_valid  in  1  store snoop.
- st_addr  in  ADDR_W  store address.
- flush  in  1  invalidate whole table.
- dmem_req_valid  out  1  miss read request.
- dmem_req_ready  in  1  memory accepts request.
- dmem_req_addr  out  ADDR_W  miss address.
- dmem_resp_valid  in  1  read data returned.
- dmem_resp_data  in  DATA_W  read data.
- port_lb_table_valid  out  1  last-written entry valid.
- port_lb_table_addr  out  ADDR_W  last-written entry address.
- port_lb_table_data  out  DATA_W  last-written entry data.

Behaviour:
- Reset (async, reset_n low):
  - State IDLE; all entry valid bits 0; rr_ptr 0; poison 0.
  - All outputs 0, except ld_req_ready=1 once reset_n is high.
  - Reset mid-miss abandons the transaction; no response is produced.
- FSM states: IDLE, LOOKUP, MISS_REQ, MISS_WAIT, RESP.
- IDLE: ld_req_valid latches the address -> LOOKUP.
- LOOKUP: full-address compare against all valid entries.
  - Hit: ld_resp_valid=1, ld_resp_hit=1, data = entry data (same cycle) -> IDLE. Hit latency is 1 cycle after acceptance.
  - Miss: -> MISS_REQ.
- MISS_REQ: dmem_req_valid=1 with the latched address, held stable until dmem_req_ready -> MISS_WAIT.
- MISS_WAIT: on dmem_resp_valid, capture data.
  - If poison=0: write the victim entry (valid=1, addr, data).
  - Go to RESP.
- RESP: ld_resp_valid=1, ld_resp_hit=0, data = captured data; clear poison -> IDLE.
  - Miss latency = 3 + request wait + response wait cycles.
- Victim selection: lowest-index invalid entry; if none, entry rr_ptr.
  - rr_ptr increments modulo ENTRIES only when a valid entry is evicted.
- Store snoop (any state): st_valid clears valid on every entry whose addr == st_addr.
  - Store and lookup on the same address in the same cycle: store wins; lookup reports a miss.
  - Store matching the pending miss address during MISS_REQ/MISS_WAIT sets poison. Data is still returned; no fill.
- flush (any state): clears all valid bits and rr_ptr. If a miss is outstanding, sets poison; the transaction completes and responds.
- Store/flush in the same cycle as a fill: the fill is suppressed if the fill address matches the store or flush is high.
- Observation ports are registered:
  - Updated on every fill with the written entry.
  - port_lb_table_valid drops when that entry is invalidated (store, flush or eviction by another fill overwrites).
- ld_req_valid outside IDLE is ignored; the requester holds until ld_req_ready.

Decomposition:
- Package lb_pkg:
  - FSM state enum.
  - Entry struct {valid, addr, data}.
  - Default ENTRIES/ADDR_W/DATA_W constants.
  - clog2-based index width.
- Sub-module lb_match:
  - Parallel address compare giving one-hot hit plus encoded index.
  - First-invalid priority encoder.
  - Shared by lookup and store snoop.

Test Plan:
- Cold load 0x64, dmem returns 0xDEADBEEF after 2 cycles -> one response, hit=0, data 0xDEADBEEF; port_lb_table_valid=1, addr 0x64.
- Repeat load 0x64 -> ld_resp_valid exactly 1 cycle after acceptance, hit=1, data 0xDEADBEEF; no dmem_req_valid.
- Fill 0x0,0x4,0x8,0xC (ENTRIES=4), then load 0x10 -> evicts entry 0 (rr_ptr 0->1); next load 0x14 evicts entry 1.
- Store 0x64 during MISS_WAIT for load 0x64 -> response data returned, hit=0; subsequent load 0x64 misses again.
- Lookup 0x4 with st_valid/st_addr 0x4 in the same LOOKUP cycle -> miss path taken; flush pulse -> all later loads miss.
- reset_n low during MISS_WAIT -> ld_resp_valid never asserts; after release, ld_req_ready=1 and port_lb_table_valid=0.
